// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   signed_div 1 = DIV (two's complement), 0 = DIVU; sampled with start
//   a, b       dividend / divisor; sampled with start
//   start      launch a division; honoured only in IDLE
//   annul      abort an operation in flight (ON or DZERO)
//   busy       high in ON and DZERO; EX stalls while high
//   ready      one-cycle pulse, result valid in that cycle
//   result     {remainder (HI), quotient (LO)}; held until the next completion

module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 start,
    input  logic                 annul,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ON    = 2'd1,
        DZERO = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]    count;
    // Partial remainder is kept WIDTH bits wide: after every step it is
    // strictly below the divisor, so the extra bit of the shifted value is
    // only needed transiently for the trial subtraction.
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             sgn_q;
    logic             sgn_r;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             last;
    logic             launch;
    logic             b_zero;

    assign b_zero = (b == '0);
    assign launch = (state == IDLE) && start && !annul;
    assign last   = (count == CW'(WIDTH - 1));

    // Magnitudes only in signed mode; -2^(W-1) maps onto itself, which is
    // the correct unsigned magnitude.
    assign abs_a = (signed_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign abs_b = (signed_div && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        rem_next = shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
        quo_fix = sgn_q ? (~quo_next + 1'b1) : quo_next;
        rem_fix = sgn_r ? (~rem_next + 1'b1) : rem_next;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; annul beats start and aborts ON/DZERO.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !annul) begin
                    state_next = b_zero ? DZERO : ON;
                end
            end
            ON: begin
                if (annul) begin
                    state_next = IDLE;
                end else if (last) begin
                    state_next = DONE;
                end
            end
            DZERO: begin
                state_next = annul ? IDLE : DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy  = (state == ON) || (state == DZERO);
        ready = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            sgn_q   <= 1'b0;
            sgn_r   <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        count   <= '0;
                        rem     <= '0;
                        // Divide-by-zero reports the raw dividend in HI, so
                        // the quotient register carries it through DZERO.
                        quo     <= b_zero ? a : abs_a;
                        divisor <= abs_b;
                        sgn_q   <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sgn_r   <= signed_div & a[WIDTH-1];
                    end
                end
                ON: begin
                    if (!annul) begin
                        rem   <= rem_next;
                        quo   <= quo_next;
                        count <= count + 1'b1;
                        if (last) begin
                            result <= {rem_fix, quo_fix};
                        end
                    end
                end
                DZERO: begin
                    if (!annul) begin
                        result <= {quo, {WIDTH{1'b1}}};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit

module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           signed_div = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           start = 1'b0;
    logic           annul = 1'b0;
    logic           busy;
    logic           ready;
    logic [2*W-1:0] result;

    int errors = 0;
    int checks = 0;
    logic [63:0] last_res = '0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .start      (start),
        .annul      (annul),
        .busy       (busy),
        .ready      (ready),
        .result     (result)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // HI = remainder (sign of dividend), LO = quotient truncated toward zero.
    function automatic logic [63:0] model(input bit sd, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (!sd) return {x % y, x / y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Launch one division and check latency, pulse width and result.
    // inject_at > 0 fires a second start with other operands in that cycle.
    task automatic do_op(input string tag, input bit sd, input logic [31:0] x,
                         input logic [31:0] y, input int inject_at);
        logic [63:0] exp;
        int k;
        int lat_exp;
        exp     = model(sd, x, y);
        lat_exp = (y == 32'h0) ? 2 : 33;
        signed_div = sd;
        a = x;
        b = y;
        start = 1'b1;
        tick;
        start = 1'b0;
        a = ~x;
        b = y + 32'd1;
        signed_div = ~sd;
        k = 1;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        while (!ready && k < 45) begin
            if (k == inject_at) begin
                a = $urandom;
                b = $urandom | 32'h1;
                start = 1'b1;
            end
            tick;
            start = 1'b0;
            k++;
        end
        check({tag, "_lat"}, 64'(k), 64'(lat_exp));
        check({tag, "_res"}, result, exp);
        check({tag, "_busy_rdy"}, 64'(busy), 64'd0);
        tick;
        check({tag, "_pulse"}, 64'(ready), 64'd0);
        last_res = exp;
    endtask

    initial begin
        int k;
        int pulses;
        bit sd;
        logic [31:0] x;
        logic [31:0] y;

        rst = 1'b0;
        repeat (3) tick;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_result", result, 64'd0);
        rst = 1'b1;
        tick;

        do_op("u7_2", 1'b0, 32'd7, 32'd2, 0);
        check("u7_2_const", result, {32'h1, 32'h3});
        do_op("sm7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        check("sm7_2_const", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op("s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        check("s7_m2_const", result, {32'h1, 32'hFFFF_FFFD});
        do_op("u_big", 1'b0, 32'hFFFF_FFFF, 32'd2, 0);
        check("u_big_const", result, {32'h1, 32'h7FFF_FFFF});
        do_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("s_ovf_const", result, {32'h0, 32'h8000_0000});
        do_op("dz", 1'b0, 32'h1234, 32'h0, 0);
        check("dz_const", result, {32'h1234, 32'hFFFF_FFFF});
        do_op("s_dz", 1'b1, 32'h8000_0001, 32'h0, 0);

        for (int i = 0; i < 16; i++) begin
            sd = 1'($urandom_range(0, 1));
            x  = $urandom;
            if ($urandom_range(0, 7) == 0) y = 32'h0;
            else if ($urandom_range(0, 1) == 1) y = 32'($urandom_range(1, 255));
            else y = $urandom;
            if ($urandom_range(0, 1) == 1) y = -y;
            do_op("rand", sd, x, y, 0);
        end

        // Annul in the tenth ON cycle.
        signed_div = 1'b0;
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        tick;
        start = 1'b0;
        k = 1;
        while (k < 10) begin
            tick;
            k++;
        end
        annul = 1'b1;
        tick;
        annul = 1'b0;
        check("annul_busy", 64'(busy), 64'd0);
        pulses = 0;
        repeat (40) begin
            if (ready) pulses++;
            tick;
        end
        check("annul_no_ready", 64'(pulses), 64'd0);
        check("annul_hold", result, last_res);
        do_op("annul_retry", 1'b0, 32'd100, 32'd7, 0);
        check("annul_retry_const", result, {32'h2, 32'hE});

        // Annul beats start in IDLE.
        a = 32'd9;
        b = 32'd3;
        start = 1'b1;
        annul = 1'b1;
        tick;
        start = 1'b0;
        annul = 1'b0;
        check("prio_busy", 64'(busy), 64'd0);
        pulses = 0;
        repeat (40) begin
            if (ready) pulses++;
            tick;
        end
        check("prio_no_ready", 64'(pulses), 64'd0);
        check("prio_hold", result, last_res);

        // Second start while busy is ignored.
        do_op("ignored", 1'b0, 32'd1000, 32'd3, 10);
        pulses = 0;
        repeat (40) begin
            if (ready) pulses++;
            tick;
        end
        check("ignored_one_pulse", 64'(pulses), 64'd0);
        check("ignored_hold", result, {32'd1, 32'd333});

        // Reset in the fifth ON cycle.
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_result", result, 64'd0);
        pulses = 0;
        repeat (40) begin
            if (ready) pulses++;
            tick;
        end
        check("midrst_no_ready", 64'(pulses), 64'd0);
        do_op("after_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
